// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding, common
// keyboard command bytes and default timing in 100 MHz clk cycles.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        RELEASE,
        FINISH
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam int DEFAULT_INHIBIT_CYCLES = 10000;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1500000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus a one-cycle pulse on
// each falling edge of the synchronized level.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame,
// ACK check). Optional macro PS2_TX_RETRY_EN retries one failed attempt.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // INHIBIT_CYCLES must be at least 2 so the start bit lands in the last cycle only.
    localparam logic [CNT_W-1:0] INHIBIT_LAST    = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INHIBIT_PRELAST = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [3:0]       edge_cnt;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             nack_q;
    logic             can_retry;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (ps2_data_i),
        .level (data_level),
        .fall  (data_fall)
    );

`ifdef PS2_TX_RETRY_EN
    logic retried_q;
    assign can_retry = ~retried_q;
`else
    assign can_retry = 1'b0;
`endif

    // One counter serves both the inhibit hold and the per-attempt timeout;
    // it restarts at each INHIBIT entry and again at RTS entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            tx_ready    <= 1'b1;
            cycle_cnt   <= '0;
            edge_cnt    <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            nack_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (tx_valid) begin
                        data_q      <= tx_data;
                        parity_q    <= odd_parity(tx_data);
                        nack_q      <= 1'b0;
                        busy        <= 1'b1;
                        tx_ready    <= 1'b0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        cycle_cnt   <= '0;
                        state       <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retried_q   <= 1'b0;
`endif
                    end
                end

                INHIBIT: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (cycle_cnt == INHIBIT_PRELAST) begin
                        ps2_data_oe <= 1'b1;
                    end
                    if (cycle_cnt == INHIBIT_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        cycle_cnt   <= '0;
                        edge_cnt    <= '0;
                        state       <= RTS;
                    end
                end

                RTS, SEND, ACK, RELEASE: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (cycle_cnt == TIMEOUT_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (can_retry) begin
                            ps2_clk_oe <= 1'b1;
                            cycle_cnt  <= '0;
                            state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            retried_q  <= 1'b1;
`endif
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end
                    end else if (state == RELEASE) begin
                        // Hand the bus back only once both lines are quietly high.
                        if (clk_level && data_level && !clk_fall && !data_fall) begin
                            if (nack_q && can_retry) begin
                                ps2_clk_oe <= 1'b1;
                                cycle_cnt  <= '0;
                                state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                                retried_q  <= 1'b1;
`endif
                            end else begin
                                done  <= 1'b1;
                                err   <= nack_q;
                                state <= FINISH;
                            end
                        end
                    end else if (clk_fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (state == ACK) begin
                            nack_q <= data_level;
                            state  <= RELEASE;
                        end else if (edge_cnt < 4'd8) begin
                            ps2_data_oe <= ~data_q[edge_cnt[2:0]];
                            state       <= SEND;
                        end else if (edge_cnt == 4'd8) begin
                            ps2_data_oe <= ~parity_q;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end
                    end
                end

                FINISH: begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a behavioural PS/2 keyboard on the
// open-drain lines; frame, parity and outcome are predicted from the byte alone.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 2000;

    localparam int MODE_ACK    = 0;
    localparam int MODE_NACK   = 1;
    localparam int MODE_SILENT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic clk_line;
    logic data_line;

    int         dev_mode = MODE_ACK;
    int         dev_bits = 0;
    logic [9:0] dev_word = '0;

    int checks = 0;
    int fails  = 0;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Keyboard: after the host inhibit it answers a request-to-send with 11
    // clock pulses, reading each bit just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (clk_line == 1'b0) begin
                wait (clk_line == 1'b1);
                @(negedge clk);
                if (data_line == 1'b0 && dev_mode != MODE_SILENT) begin
                    dev_bits = 0;
                    dev_word = '0;
                    repeat (15) @(negedge clk);
                    for (int p = 1; p <= 11; p++) begin
                        dev_clk = 1'b0;
                        repeat (10) @(negedge clk);
                        if (p <= 10) begin
                            dev_word[p-1] = data_line;
                            dev_bits = p;
                        end
                        dev_clk = 1'b1;
                        if (p == 10) begin
                            repeat (5) @(negedge clk);
                            dev_data = (dev_mode == MODE_NACK);
                            repeat (5) @(negedge clk);
                        end else begin
                            repeat (10) @(negedge clk);
                        end
                    end
                    repeat (2) @(negedge clk);
                    dev_data = 1'b1;
                end
            end
        end
    end

    task automatic observeTx(input logic [7:0] d, input int mode, input bit hold, input bit drop_at_done,
                             input string tag);
        int   t = 0;
        int   seg_len = 0;
        int   segments = 0;
        int   rts_t = -1;
        int   done_t = -1;
        int   exp_segments = 1;
        int   budget = 2 * (INH + TO) + 1000;
        logic prev_clk_oe = 1'b0;
        logic prev_data_oe = 1'b0;
        logic prev2_data_oe = 1'b0;
        logic err_at_done = 1'b0;
        logic exp_err = (mode != MODE_ACK);
        logic exp_parity = (($countones(d) % 2) == 0);
`ifdef PS2_TX_RETRY_EN
        if (mode != MODE_ACK) exp_segments = 2;
`endif
        while (done_t < 0 && t < budget) begin
            @(negedge clk);
            t++;
            if (!hold && busy && tx_valid) begin
                tx_valid = 1'b0;
                tx_data  = ~d;
            end
            if (ps2_clk_oe) begin
                if (!prev_clk_oe) begin
                    segments++;
                    seg_len = 0;
                end
                seg_len++;
            end else if (prev_clk_oe) begin
                checkOutput({tag, "_inhibit_len"}, seg_len, INH);
                checkOutput({tag, "_start_bit_last_inhibit"}, prev_data_oe, 1);
                checkOutput({tag, "_data_free_early_inhibit"}, prev2_data_oe, 0);
                rts_t = t;
            end
            if (done) begin
                done_t = t;
                err_at_done = err;
                if (drop_at_done) tx_valid = 1'b0;
            end
            prev2_data_oe = prev_data_oe;
            prev_data_oe  = ps2_data_oe;
            prev_clk_oe   = ps2_clk_oe;
        end
        checkOutput({tag, "_done_seen"}, done_t > 0, 1);
        if (done_t > 0) begin
            checkOutput({tag, "_err"}, err_at_done, exp_err);
            checkOutput({tag, "_attempts"}, segments, exp_segments);
            if (mode == MODE_SILENT)
                checkOutput({tag, "_timeout_latency"}, done_t - rts_t, TO);
            else
                checkOutput({tag, "_frame"}, dev_word, {1'b1, exp_parity, d});
            @(negedge clk);
            checkOutput({tag, "_done_one_cycle"}, done, 0);
            checkOutput({tag, "_ready_after"}, tx_ready, 1);
            checkOutput({tag, "_busy_after"}, busy, 0);
            checkOutput({tag, "_oe_after"}, {ps2_clk_oe, ps2_data_oe}, 0);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int mode, input string tag);
        int w = 0;
        while (!tx_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, "_ready_before"}, tx_ready, 1);
        dev_mode = mode;
        tx_data  = d;
        tx_valid = 1'b1;
        observeTx(d, mode, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        checkOutput("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        checkOutput("reset_flags", {busy, done, err}, 0);
        checkOutput("reset_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        applyStimulus(8'hED, MODE_ACK, "set_leds");
        applyStimulus(8'hFF, MODE_NACK, "nack_reset");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "random");
        end

        applyStimulus(8'hA5, MODE_SILENT, "timeout");

        // Abort mid-frame, then prove the bus is usable again.
        begin
            int w = 0;
            int done_cnt = 0;
            int busy_cnt = 0;
            dev_mode = MODE_ACK;
            @(negedge clk);
            tx_data  = 8'h5A;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            while (dev_bits != 4 && w < 2000) begin
                @(negedge clk);
                w++;
            end
            checkOutput("abort_reached_bit4", dev_bits, 4);
            #2 rst = 1'b0;
            #1;
            checkOutput("abort_oe_async", {ps2_clk_oe, ps2_data_oe}, 0);
            checkOutput("abort_busy_async", busy, 0);
            checkOutput("abort_ready_async", tx_ready, 1);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (300) begin
                @(negedge clk);
                if (done) done_cnt++;
                if (busy) busy_cnt++;
            end
            checkOutput("abort_no_done", done_cnt, 0);
            checkOutput("abort_stays_idle", busy_cnt, 0);
        end
        applyStimulus(8'hF4, MODE_ACK, "after_abort");

        // tx_valid held across a transaction yields back-to-back transfers.
        dev_mode = MODE_ACK;
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        observeTx(8'h3C, MODE_ACK, 1'b1, 1'b0, "hold_first");
        observeTx(8'h3C, MODE_ACK, 1'b1, 1'b1, "hold_second");
        repeat (5) @(negedge clk);
        checkOutput("hold_no_third", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
